// File: rtl/reimu_shot_pool.sv
// Multi-slot player shot engine: spawns bullets with cooldown, moves them upward, resolves boss/enemy hits, owns HP.
// Build option REIMU_SHOT_DEADSKIP_EN: targets at HP 0 are transparent to bullets.
//
// slot state | meaning
// S_IDLE     | slot free, bul_v=0, x/y follow the player position
// S_FLY      | bullet in flight, bul_v=1, moving upward until hit or off top
module reimu_shot_pool #(
   parameter int NSLOT    = 4,
   parameter int NENM     = 4,
   parameter int BOSS_HP  = 450,
   parameter int ENM_HP   = 120,
   parameter int COOLDOWN = 16
) (
   input  logic                 clk_22,
   input  logic                 rst,
   input  logic                 gamestart,
   input  logic                 shoot,
   input  logic                 reimuE,
   input  logic [9:0]           reimux,
   input  logic [9:0]           reimuy,
   input  logic [9:0]           bossx,
   input  logic [9:0]           bossy,
   input  logic [10*NENM-1:0]   enmx,
   input  logic [10*NENM-1:0]   enmy,
   output logic [10*NSLOT-1:0]  bul_x,
   output logic [10*NSLOT-1:0]  bul_y,
   output logic [NSLOT-1:0]     bul_v,
   output logic [7*NENM-1:0]    enmhp,
   output logic [9:0]           bosshp,
   output logic                 shot_boss,
   output logic                 shot_enm,
   output logic                 fire
);

   localparam int CDW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_FLY = 1'b1} slot_st_e;

   slot_st_e       st_q [NSLOT];
   slot_st_e       st_d [NSLOT];
   logic [9:0]     x_q [NSLOT];
   logic [9:0]     x_d [NSLOT];
   logic [9:0]     y_q [NSLOT];
   logic [9:0]     y_d [NSLOT];
   logic [CDW-1:0] cd_q, cd_d;
   logic [9:0]     boss_hp_q, boss_hp_d;
   logic [6:0]     enm_hp_q [NENM];
   logic [6:0]     enm_hp_d [NENM];
   logic           shot_boss_q, shot_boss_d;
   logic           shot_enm_q, shot_enm_d;
   logic           fire_q, fire_d;

   logic [10:0]      boss_xlo, boss_xhi, boss_ylo, boss_yhi;
   logic [10:0]      enm_xlo [NENM];
   logic [10:0]      enm_xhi [NENM];
   logic [10:0]      enm_ylo [NENM];
   logic [10:0]      enm_yhi [NENM];
   logic             boss_live;
   logic [NENM-1:0]  enm_live;

   logic [NSLOT-1:0] free_sel;
   logic [NENM-1:0]  enm_hit;
   logic             any_free, spawn, boss_hit, slot_hit;
   logic [9:0]       step;

   function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                   input logic [10:0] xlo, input logic [10:0] xhi,
                                   input logic [10:0] ylo, input logic [10:0] yhi);
      return ({1'b0, px} >= xlo) && ({1'b0, px} <= xhi) &&
             ({1'b0, py} >= ylo) && ({1'b0, py} <= yhi);
   endfunction

   // Boxes widened to 11 bits so centres near the screen edge neither wrap low nor overflow high.
   always_comb begin
      boss_xlo = (bossx >= 10'd25) ? ({1'b0, bossx} - 11'd25) : 11'd0;
      boss_xhi = {1'b0, bossx} + 11'd25;
      boss_ylo = (bossy >= 10'd37) ? ({1'b0, bossy} - 11'd37) : 11'd0;
      boss_yhi = {1'b0, bossy} + 11'd38;
      for (int e = 0; e < NENM; e++) begin
         enm_xlo[e] = (enmx[10*e +: 10] >= 10'd14) ? ({1'b0, enmx[10*e +: 10]} - 11'd14) : 11'd0;
         enm_xhi[e] = {1'b0, enmx[10*e +: 10]} + 11'd14;
         enm_ylo[e] = (enmy[10*e +: 10] >= 10'd14) ? ({1'b0, enmy[10*e +: 10]} - 11'd14) : 11'd0;
         enm_yhi[e] = {1'b0, enmy[10*e +: 10]} + 11'd14;
      end
   end

`ifdef REIMU_SHOT_DEADSKIP_EN
   always_comb begin
      boss_live = (boss_hp_q != 10'd0);
      for (int e = 0; e < NENM; e++) enm_live[e] = (enm_hp_q[e] != 7'd0);
   end
`else
   always_comb begin
      boss_live = 1'b1;
      enm_live  = '1;
   end
`endif

   always_comb begin
      any_free = 1'b0;
      free_sel = '0;
      for (int s = 0; s < NSLOT; s++) begin
         free_sel[s] = (st_q[s] == S_IDLE) && !any_free;
         any_free    = any_free | (st_q[s] == S_IDLE);
      end
      spawn = shoot && reimuE && (cd_q == '0) && any_free;

      boss_hit = 1'b0;
      enm_hit  = '0;
      slot_hit = 1'b0;
      step     = 10'd0;
      for (int s = 0; s < NSLOT; s++) begin
         st_d[s]  = st_q[s];
         x_d[s]   = x_q[s];
         y_d[s]   = y_q[s];
         slot_hit = 1'b0;
         step     = (y_q[s] <= 10'd120) ? 10'd1 : (y_q[s] <= 10'd240) ? 10'd2 : 10'd4;
         if (st_q[s] == S_FLY) begin
            if (boss_live && in_box(x_q[s], y_q[s], boss_xlo, boss_xhi, boss_ylo, boss_yhi)) begin
               slot_hit = 1'b1;
               boss_hit = 1'b1;
            end
            for (int e = 0; e < NENM; e++) begin
               if (!slot_hit && enm_live[e] &&
                   in_box(x_q[s], y_q[s], enm_xlo[e], enm_xhi[e], enm_ylo[e], enm_yhi[e])) begin
                  slot_hit   = 1'b1;
                  enm_hit[e] = 1'b1;
               end
            end
            if (slot_hit || (y_q[s] < step)) st_d[s] = S_IDLE;
            else                             y_d[s]  = y_q[s] - step;
         end else if (spawn && free_sel[s]) begin
            st_d[s] = S_FLY;
         end
         // Free, freshly freed and freshly spawned slots all sit on the player.
         if ((st_q[s] == S_IDLE) || (st_d[s] == S_IDLE)) begin
            x_d[s] = reimux;
            y_d[s] = reimuy;
         end
      end

      cd_d = cd_q;
      if (spawn)                          cd_d = CDW'(COOLDOWN - 1);
      else if (any_free && cd_q != '0)    cd_d = cd_q - 1'b1;

      boss_hp_d = (boss_hit && boss_hp_q != 10'd0) ? (boss_hp_q - 10'd1) : boss_hp_q;
      for (int e = 0; e < NENM; e++)
         enm_hp_d[e] = (enm_hit[e] && enm_hp_q[e] != 7'd0) ? (enm_hp_q[e] - 7'd1) : enm_hp_q[e];

      shot_boss_d = boss_hit;
      shot_enm_d  = |enm_hit;
      fire_d      = spawn;

      if (!reimuE) begin
         for (int s = 0; s < NSLOT; s++) begin
            st_d[s] = S_IDLE;
            x_d[s]  = reimux;
            y_d[s]  = reimuy;
         end
         cd_d        = '0;
         boss_hp_d   = boss_hp_q;
         for (int e = 0; e < NENM; e++) enm_hp_d[e] = enm_hp_q[e];
         shot_boss_d = 1'b0;
         shot_enm_d  = 1'b0;
         fire_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_22) begin
      if (rst || gamestart) begin
         for (int s = 0; s < NSLOT; s++) begin
            st_q[s] <= S_IDLE;
            x_q[s]  <= reimux;
            y_q[s]  <= reimuy;
         end
         cd_q        <= '0;
         boss_hp_q   <= 10'(BOSS_HP);
         for (int e = 0; e < NENM; e++) enm_hp_q[e] <= 7'(ENM_HP);
         shot_boss_q <= 1'b0;
         shot_enm_q  <= 1'b0;
         fire_q      <= 1'b0;
      end else begin
         st_q        <= st_d;
         x_q         <= x_d;
         y_q         <= y_d;
         cd_q        <= cd_d;
         boss_hp_q   <= boss_hp_d;
         enm_hp_q    <= enm_hp_d;
         shot_boss_q <= shot_boss_d;
         shot_enm_q  <= shot_enm_d;
         fire_q      <= fire_d;
      end
   end

   for (genvar s = 0; s < NSLOT; s++) begin : g_slot
      assign bul_x[10*s +: 10] = x_q[s];
      assign bul_y[10*s +: 10] = y_q[s];
      assign bul_v[s]          = (st_q[s] == S_FLY);
   end

   for (genvar e = 0; e < NENM; e++) begin : g_enm
      assign enmhp[7*e +: 7] = enm_hp_q[e];
   end

   assign bosshp    = boss_hp_q;
   assign shot_boss = shot_boss_q;
   assign shot_enm  = shot_enm_q;
   assign fire      = fire_q;

endmodule

// File: tb/tb_reimu_shot_pool.sv
// Scoreboard bench for reimu_shot_pool: stimulus queues expected fire/hit pulses, a monitor pops and compares them.
module tb_reimu_shot_pool;

   logic        clk_22 = 1'b0;
   logic        rst, gamestart, shoot, reimuE;
   logic [9:0]  reimux, reimuy, bossx, bossy;
   logic [39:0] enmx, enmy;
   logic [39:0] bul_x, bul_y;
   logic [3:0]  bul_v;
   logic [27:0] enmhp;
   logic [9:0]  bosshp;
   logic        shot_boss, shot_enm, fire;

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;
   int t0, c;

   typedef struct {int cyc; int val;} exp_t;
   exp_t q_fire[$];
   exp_t q_boss[$];
   exp_t q_enm[$];
   exp_t e;

   reimu_shot_pool #(.NSLOT(4), .NENM(4), .BOSS_HP(450), .ENM_HP(120), .COOLDOWN(16)) dut (
      .clk_22(clk_22), .rst(rst), .gamestart(gamestart), .shoot(shoot), .reimuE(reimuE),
      .reimux(reimux), .reimuy(reimuy), .bossx(bossx), .bossy(bossy),
      .enmx(enmx), .enmy(enmy), .bul_x(bul_x), .bul_y(bul_y), .bul_v(bul_v),
      .enmhp(enmhp), .bosshp(bosshp), .shot_boss(shot_boss), .shot_enm(shot_enm), .fire(fire)
   );

   always #5 clk_22 = ~clk_22;
   always @(posedge clk_22) cyc <= cyc + 1;

   function automatic int pk(input int h0, input int h1, input int h2, input int h3);
      return (h3 << 21) | (h2 << 14) | (h1 << 7) | h0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_ev(input string name, input exp_t ex, input int val);
      n_chk++;
      if (ex.cyc != cyc || ex.val != val) begin
         n_fail++;
         $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d", name, cyc, val, ex.cyc, ex.val);
      end
   endtask

   task automatic unexpected(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
   endtask

   always @(negedge clk_22) begin
      if (fire === 1'b1) begin
         if (q_fire.size() == 0) unexpected("fire");
         else begin e = q_fire.pop_front(); check_ev("fire", e, int'(bul_v)); end
      end
      if (shot_boss === 1'b1) begin
         if (q_boss.size() == 0) unexpected("shot_boss");
         else begin e = q_boss.pop_front(); check_ev("shot_boss", e, int'(bosshp)); end
      end
      if (shot_enm === 1'b1) begin
         if (q_enm.size() == 0) unexpected("shot_enm");
         else begin e = q_enm.pop_front(); check_ev("shot_enm", e, int'(enmhp)); end
      end
   end

   task automatic set_enm(input int i, input int x, input int y);
      enmx[10*i +: 10] = 10'(x);
      enmy[10*i +: 10] = 10'(y);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk_22);
   endtask

   task automatic park();
      shoot = 0; reimuE = 1; gamestart = 0;
      reimux = 320; reimuy = 400;
      bossx = 100; bossy = 100;
      for (int i = 0; i < 4; i++) set_enm(i, 900, 50);
   endtask

   task automatic do_reset();
      rst = 1;
      @(negedge clk_22);
      rst = 0;
   endtask

   initial begin
      #300000;
      n_chk++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      rst = 1;
      park();
      @(negedge clk_22);
      @(negedge clk_22);
      rst = 0;
      check("rst_bul_v", bul_v, 0);
      check("rst_bosshp", bosshp, 450);
      check("rst_enmhp", enmhp, pk(120, 120, 120, 120));
      check("rst_bul_x0", bul_x[9:0], 320);
      check("rst_bul_y3", bul_y[39:30], 400);
      check("rst_pulses", {shot_boss, shot_enm, fire}, 0);

      // sustained fire, nothing in the path
      t0 = cyc + 1;
      shoot = 1;
      for (int j = 0; j < 4; j++) q_fire.push_back(exp_t'{t0 + 16*j, (1 << (j+1)) - 1});
      wait_to(t0 + 1);   check("a_y0_k1", bul_y[9:0], 396);
      wait_to(t0 + 40);  check("a_y0_k40", bul_y[9:0], 240);
      wait_to(t0 + 41);  check("a_y0_k41", bul_y[9:0], 238);
      wait_to(t0 + 48);  check("a_slot3_y", bul_y[39:30], 400);
      wait_to(t0 + 70);  check("a_all_busy", bul_v, 4'hf);
      wait_to(t0 + 100); check("a_y0_k100", bul_y[9:0], 120);
      wait_to(t0 + 101); check("a_y0_k101", bul_y[9:0], 119);
      wait_to(t0 + 200); shoot = 0;
      wait_to(t0 + 220); check("a_y0_top", bul_y[9:0], 0);
      check("a_v0_top", bul_v[0], 1);
      wait_to(t0 + 221); check("a_v0_gone", bul_v[0], 0);
      check("a_y0_track", bul_y[9:0], 400);

      // boss hit from below
      park(); do_reset();
      bossx = 320; bossy = 100;
      t0 = cyc + 1;
      shoot = 1;
      q_fire.push_back(exp_t'{t0, 1});
      q_boss.push_back(exp_t'{t0 + 92, 449});
      wait_to(t0); shoot = 0;
      wait_to(t0 + 91); check("b_y_before", bul_y[9:0], 138);
      check("b_v_before", bul_v, 1);
      wait_to(t0 + 92); check("b_absorbed", bul_v, 0);
      wait_to(t0 + 93); check("b_pulse_end", shot_boss, 0);
      check("b_bosshp", bosshp, 449);

      // two overlapping enemies, priority to enemy 0
      park(); do_reset();
      set_enm(0, 320, 300); set_enm(1, 320, 300);
      t0 = cyc + 1;
      shoot = 1;
      q_fire.push_back(exp_t'{t0, 1});
      q_enm.push_back(exp_t'{t0 + 23, pk(119, 120, 120, 120)});
      wait_to(t0); shoot = 0;
      wait_to(t0 + 23); check("c_absorbed", bul_v, 0);
      wait_to(t0 + 24); check("c_pulse_end", shot_enm, 0);
      check("c_enmhp", enmhp, pk(119, 120, 120, 120));

      // player death mid-flight, then gamestart
      set_enm(0, 900, 50); set_enm(1, 900, 50);
      c = cyc;
      shoot = 1;
      q_fire.push_back(exp_t'{c + 1, 1});
      q_fire.push_back(exp_t'{c + 17, 3});
      q_fire.push_back(exp_t'{c + 33, 7});
      wait_to(c + 33); shoot = 0;
      wait_to(c + 35); reimuE = 0;
      wait_to(c + 36); check("f_dead_v", bul_v, 0);
      check("f_dead_enmhp", enmhp, pk(119, 120, 120, 120));
      check("f_dead_bosshp", bosshp, 450);
      reimuE = 1; shoot = 1;
      q_fire.push_back(exp_t'{c + 37, 1});
      wait_to(c + 44); gamestart = 1;
      wait_to(c + 45); gamestart = 0;
      check("f_gs_v", bul_v, 0);
      check("f_gs_enmhp", enmhp, pk(120, 120, 120, 120));
      check("f_gs_fire", fire, 0);
      q_fire.push_back(exp_t'{c + 46, 1});
      wait_to(c + 46); shoot = 0;

      // two bullets into enemy 2 on the same tick
      park(); do_reset();
      t0 = cyc + 1;
      shoot = 1;
      q_fire.push_back(exp_t'{t0, 1});
      q_fire.push_back(exp_t'{t0 + 16, 3});
      wait_to(t0); reimux = 340;
      wait_to(t0 + 16); shoot = 0; reimux = 320;
      q_enm.push_back(exp_t'{t0 + 121, pk(120, 120, 119, 120)});
      wait_to(t0 + 120); check("d_y0", bul_y[9:0], 100);
      check("d_y1", bul_y[19:10], 116);
      check("d_x1", bul_x[19:10], 340);
      set_enm(2, 330, 108);
      wait_to(t0 + 121); check("d_both_freed", bul_v, 0);
      wait_to(t0 + 125); check("d_enmhp", enmhp, pk(120, 120, 119, 120));

      // drain enemy 0 to zero, then one more bullet with the boss behind it
      park(); do_reset();
      set_enm(0, 320, 384);
      bossx = 320; bossy = 300;
      t0 = cyc + 1;
      shoot = 1;
      for (int j = 0; j <= 120; j++) begin
         q_fire.push_back(exp_t'{t0 + 16*j, 1});
         if (j < 120) q_enm.push_back(exp_t'{t0 + 16*j + 2, pk(119 - j, 120, 120, 120)});
      end
`ifdef REIMU_SHOT_DEADSKIP_EN
      q_boss.push_back(exp_t'{t0 + 16*120 + 17, 449});
`else
      q_enm.push_back(exp_t'{t0 + 16*120 + 2, pk(0, 120, 120, 120)});
`endif
      wait_to(t0 + 16*120); shoot = 0;
      wait_to(t0 + 16*120 + 20);
      check("e_enm0_zero", enmhp, pk(0, 120, 120, 120));
`ifdef REIMU_SHOT_DEADSKIP_EN
      check("e_bosshp", bosshp, 449);
`else
      check("e_bosshp", bosshp, 450);
`endif
      check("e_idle", bul_v, 0);

      wait_to(cyc + 5);
      check("fire_missing", q_fire.size(), 0);
      check("boss_missing", q_boss.size(), 0);
      check("enm_missing", q_enm.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
